fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 19 +
 rtl/fetch_queue.sv | 54 +++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: default PC width and reset vector, the fetch FSM
// state encoding and the layout of one fetch-queue entry.
package riscv_pkg;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] RESET_PC = 64'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO between the instruction memory response and decode.
// The flush input clears all entries; storage itself is not reset.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int W = 96,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push on a full queue is accepted only when the head leaves the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-outstanding imem request FSM and a
// fetch queue feeding decode. Define FETCH_PERF_CNT_EN to add fetch_count.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter int FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            instr_valid,
    input  logic            instr_ready,
    output fetch_state_t    dbg_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [63:0]     fetch_count
`endif
);

    // Handshakes: a request transfers when imem_req_valid & imem_req_ready at a
    // rising edge; an instruction transfers to decode when instr_valid & instr_ready.
    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam int EW = 32 + XLEN;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic [CW-1:0]   fq_count;
    logic [CW-1:0]   count_next;
    logic [EW-1:0]   fq_head;
    logic            fq_empty;
    logic            push;
    logic            pop;
    logic            issue_ok;
    logic            req_hs;

    assign pop = instr_valid & instr_ready;

    // Only request when the response is guaranteed a free queue slot.
    always_comb begin
        push       = (state == WAIT) & imem_rsp_valid & ~redirect_valid;
        count_next = fq_count + CW'(push) - CW'(pop);
        issue_ok   = ~redirect_valid &
                     ((state == IDLE) | ((state == WAIT) & imem_rsp_valid));
    end

    assign imem_req_valid = ~reset & issue_ok & (count_next < CW'(FQ_DEPTH));
    assign imem_req_addr  = pc;
    assign req_hs         = imem_req_valid & imem_req_ready;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (!redirect_valid && req_hs) state_next = WAIT;
            WAIT: begin
                if (redirect_valid)      state_next = imem_rsp_valid ? IDLE : DROP;
                else if (imem_rsp_valid) state_next = req_hs ? WAIT : IDLE;
            end
            DROP: if (imem_rsp_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            pc     <= RESET_PC & ALIGN_MASK;
            req_pc <= '0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                pc <= redirect_pc & ALIGN_MASK;
            end else if (req_hs) begin
                pc     <= pc + XLEN'(4);
                req_pc <= pc;
            end
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .W     (EW)
    ) u_queue (
        .clk       (clk),
        .rst       (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({imem_rsp_data, req_pc}),
        .pop       (pop),
        .head      (fq_head),
        .count     (fq_count),
        .empty     (fq_empty)
    );

    // Head fields read as zero when empty so reset and flush present clean outputs.
    assign instr_valid = ~fq_empty;
    assign InstrD      = instr_valid ? fq_head[EW-1:XLEN] : '0;
    assign PCD         = instr_valid ? fq_head[XLEN-1:0] : '0;
    assign PCPlus4D    = PCD + XLEN'(4);
    assign dbg_state   = state;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    fetch_count <= '0;
        else if (pop) fetch_count <= fetch_count + 64'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a configurable-latency instruction memory
// responder; expected PCs are tracked in exp_pc and instruction words by instr_of().
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [31:0] InstrD;
    logic [63:0] PCD;
    logic [63:0] PCPlus4D;
    logic        instr_valid;
    logic        instr_ready;
    fetch_state_t dbg_state;
`ifdef FETCH_PERF_CNT_EN
    logic [63:0] fetch_count;
    logic [63:0] exp_count;
`endif

    int          vectors;
    int          miscompares;
    int          rsp_lat;
    logic [63:0] exp_pc;
    logic        pend;
    logic [63:0] pend_addr;
    int          pend_wait;
    logic        r_hs;
    logic [63:0] r_addr;

    fetch_unit #(
        .XLEN     (64),
        .RESET_PC (64'h0),
        .FQ_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .dbg_state      (dbg_state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required reaching the summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'h00A0_0013;
    endfunction

    // Memory responder: samples the request just before the edge, answers rsp_lat cycles later.
    initial begin
        pend = 1'b0; pend_addr = '0; pend_wait = 0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    end
    always begin
        @(negedge clk);
        #4;
        r_hs   = imem_req_valid & imem_req_ready;
        r_addr = imem_req_addr;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (r_hs) begin
            pend = 1'b1; pend_addr = r_addr; pend_wait = rsp_lat - 1;
        end
        if (pend) begin
            if (pend_wait == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(pend_addr);
                pend = 1'b0;
            end else begin
                pend_wait--;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    initial exp_count = '0;
    always begin
        @(negedge clk);
        #4;
        if (reset) exp_count = '0;
        else if (instr_valid && instr_ready) exp_count = exp_count + 64'd1;
    end
`endif

    // driver tasks
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_wait_norsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (dbg_state == WAIT && imem_rsp_valid == 1'b0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; rsp_lat = 1;
        step(); step();
        vectors++;
        if ({imem_req_valid, instr_valid, InstrD, PCD, imem_req_addr} !== {1'b0, 1'b0, 32'h0, 64'h0, 64'h0}) begin
            miscompares++;
            $display("FAIL reset_outputs: req_valid=%b instr_valid=%b InstrD=%h PCD=%h addr=%h, required 0 0 0 0 0",
                     imem_req_valid, instr_valid, InstrD, PCD, imem_req_addr);
        end
        vectors++;
        if (dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_state: state=%0d, required %0d", dbg_state, IDLE);
        end
`ifdef FETCH_PERF_CNT_EN
        vectors++;
        if (fetch_count !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_count: fetch_count=%0d, required 0", fetch_count);
        end
`endif
        reset = 1'b0;
        #1;
        vectors++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h0}) begin
            miscompares++;
            $display("FAIL first_request: req_valid=%b addr=%h, required 1 0", imem_req_valid, imem_req_addr);
        end
        exp_pc = 64'h0;
    endtask

    task automatic test_stream();
        bit ok;
        wait_valid(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL stream_start: instr_valid=%b, required 1 within 20 cycles", instr_valid);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({instr_valid, PCD, InstrD, PCPlus4D} !== {1'b1, exp_pc, instr_of(exp_pc), exp_pc + 64'd4}) begin
                miscompares++;
                $display("FAIL stream[%0d]: valid=%b PCD=%h InstrD=%h PCPlus4D=%h, required 1 %h %h %h",
                         i, instr_valid, PCD, InstrD, PCPlus4D, exp_pc, instr_of(exp_pc), exp_pc + 64'd4);
            end
            exp_pc += 64'd4;
            step();
        end
    endtask

    task automatic test_decode_stall();
        instr_ready = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if ({instr_valid, PCD, InstrD, imem_req_valid} !== {1'b1, exp_pc, instr_of(exp_pc), 1'b0}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: valid=%b PCD=%h InstrD=%h req_valid=%b, required 1 %h %h 0",
                         i, instr_valid, PCD, InstrD, imem_req_valid, exp_pc, instr_of(exp_pc));
            end
            if (i >= 1) begin
                vectors++;
                if (dbg_state !== IDLE) begin
                    miscompares++;
                    $display("FAIL stall_state[%0d]: state=%0d, required %0d", i, dbg_state, IDLE);
                end
            end
            step();
        end
        instr_ready = 1'b1;
        #1;
        vectors++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, exp_pc + 64'd8}) begin
            miscompares++;
            $display("FAIL stall_release_req: req_valid=%b addr=%h, required 1 %h",
                     imem_req_valid, imem_req_addr, exp_pc + 64'd8);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if ({instr_valid, PCD, InstrD} !== {1'b1, exp_pc, instr_of(exp_pc)}) begin
                miscompares++;
                $display("FAIL stall_resume[%0d]: valid=%b PCD=%h InstrD=%h, required 1 %h %h",
                         i, instr_valid, PCD, InstrD, exp_pc, instr_of(exp_pc));
            end
            exp_pc += 64'd4;
            step();
        end
    endtask

    task automatic test_req_stall();
        logic [63:0] hold;
        bit ok;
        hold = exp_pc + 64'd8;
        imem_req_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({imem_req_valid, imem_req_addr} !== {1'b1, hold}) begin
                miscompares++;
                $display("FAIL req_hold[%0d]: req_valid=%b addr=%h, required 1 %h",
                         i, imem_req_valid, imem_req_addr, hold);
            end
            if (instr_valid === 1'b1) begin
                vectors++;
                if (PCD !== exp_pc) begin
                    miscompares++;
                    $display("FAIL req_drain[%0d]: PCD=%h, required %h", i, PCD, exp_pc);
                end
                exp_pc += 64'd4;
            end
            step();
        end
        imem_req_ready = 1'b1;
        #1;
        wait_valid(ok);
        vectors++;
        if (!ok || PCD !== hold) begin
            miscompares++;
            $display("FAIL req_resume: valid=%b PCD=%h, required 1 %h", instr_valid, PCD, hold);
        end
        exp_pc = hold;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({instr_valid, PCD} !== {1'b1, exp_pc}) begin
                miscompares++;
                $display("FAIL req_stream[%0d]: valid=%b PCD=%h, required 1 %h", i, instr_valid, PCD, exp_pc);
            end
            exp_pc += 64'd4;
            step();
        end
    endtask

    task automatic test_redirect_with_rsp();
        bit ok;
        redirect_valid = 1'b1;
        redirect_pc = 64'h2002;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_rsp_noreq: req_valid=%b, required 0", imem_req_valid);
        end
        step();
        redirect_valid = 1'b0;
        #1;
        vectors++;
        if ({dbg_state == IDLE, instr_valid, imem_req_valid, imem_req_addr} !== {1'b1, 1'b0, 1'b1, 64'h2000}) begin
            miscompares++;
            $display("FAIL redir_rsp_after: state=%0d valid=%b req_valid=%b addr=%h, required IDLE 0 1 2000",
                     dbg_state, instr_valid, imem_req_valid, imem_req_addr);
        end
        exp_pc = 64'h2000;
        wait_valid(ok);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({instr_valid, PCD, InstrD} !== {1'b1, exp_pc, instr_of(exp_pc)}) begin
                miscompares++;
                $display("FAIL redir_rsp_stream[%0d]: valid=%b PCD=%h InstrD=%h, required 1 %h %h",
                         i, instr_valid, PCD, InstrD, exp_pc, instr_of(exp_pc));
            end
            exp_pc += 64'd4;
            step();
        end
    endtask

    task automatic test_redirect_drop();
        bit ok;
        rsp_lat = 3;
        wait_wait_norsp(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL drop_setup: state=%0d rsp_valid=%b, required WAIT 0", dbg_state, imem_rsp_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h1003;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_noreq: req_valid=%b, required 0", imem_req_valid);
        end
        step();
        redirect_valid = 1'b0;
        #1;
        vectors++;
        if ({dbg_state == DROP, instr_valid, imem_req_valid} !== {1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL drop_state: state=%0d valid=%b req_valid=%b, required DROP 0 0",
                     dbg_state, instr_valid, imem_req_valid);
        end
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        vectors++;
        if ({ok, imem_req_addr} !== {1'b1, 64'h1000}) begin
            miscompares++;
            $display("FAIL drop_next_req: seen=%b addr=%h, required 1 1000", ok, imem_req_addr);
        end
        wait_valid(ok);
        vectors++;
        if ({ok, PCD, InstrD} !== {1'b1, 64'h1000, instr_of(64'h1000)}) begin
            miscompares++;
            $display("FAIL drop_next_pcd: valid=%b PCD=%h InstrD=%h, required 1 1000 %h",
                     ok, PCD, InstrD, instr_of(64'h1000));
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        wait_wait_norsp(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rmid_setup: state=%0d rsp_valid=%b, required WAIT 0", dbg_state, imem_rsp_valid);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({imem_req_valid, instr_valid, InstrD, PCD, imem_req_addr, dbg_state == IDLE}
            !== {1'b0, 1'b0, 32'h0, 64'h0, 64'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL rmid_outputs: req_valid=%b valid=%b InstrD=%h PCD=%h addr=%h state=%0d, required 0 0 0 0 0 IDLE",
                     imem_req_valid, instr_valid, InstrD, PCD, imem_req_addr, dbg_state);
        end
        step(); step();
        rsp_lat = 1;
        reset = 1'b0;
        #1;
        vectors++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h0}) begin
            miscompares++;
            $display("FAIL rmid_first_req: req_valid=%b addr=%h, required 1 0", imem_req_valid, imem_req_addr);
        end
        exp_pc = 64'h0;
        wait_valid(ok);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if ({instr_valid, PCD, InstrD} !== {1'b1, exp_pc, instr_of(exp_pc)}) begin
                miscompares++;
                $display("FAIL rmid_stream[%0d]: valid=%b PCD=%h InstrD=%h, required 1 %h %h",
                         i, instr_valid, PCD, InstrD, exp_pc, instr_of(exp_pc));
            end
            exp_pc += 64'd4;
            step();
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_count();
        bit ok;
        reset = 1'b1;
        instr_ready = 1'b0;
        step();
        reset = 1'b0;
        step(); step(); step();
        for (int i = 0; i < 7; i++) begin
            instr_ready = 1'b1;
            wait_valid(ok);
            step();
            instr_ready = 1'b0;
            if (i == 3) begin
                redirect_valid = 1'b1;
                redirect_pc = 64'h3000;
                step();
                redirect_valid = 1'b0;
            end
            step();
        end
        vectors++;
        if (fetch_count !== 64'd7 || exp_count !== 64'd7) begin
            miscompares++;
            $display("FAIL perf_count: fetch_count=%0d bench_count=%0d, required 7", fetch_count, exp_count);
        end
        instr_ready = 1'b1;
    endtask
`endif

    // main sequence and report
    initial begin
        vectors = 0;
        miscompares = 0;
        exp_pc = '0;
        test_reset();
        test_stream();
        test_decode_stall();
        test_req_stall();
        test_redirect_with_rsp();
        test_redirect_drop();
        rsp_lat = 3;
        test_reset_mid_wait();
`ifdef FETCH_PERF_CNT_EN
        test_perf_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
